alu_result_checker: RTL and testbench

Synthesizable self-checking responder for ALU verification: it accepts (A, B, R, op) samples over a valid/ready stream, recomputes the expected result, and keeps pass/fail counts plus first-failure capture. It sits at the receiving end of the ALU stimulus path, next to the 32-bit datapath units (and/or/add/sub/slt). Stimulus generators and on-board self-test logic use it to get a hardware pass/fail verdict instead of reading a textual monitor.

---
 rtl/alu_chk_pkg.sv | 17 +
 rtl/alu_result_checker_if.sv | 14 +
 rtl/alu_ref_model.sv | 28 ++
 rtl/alu_result_checker.sv | 158 +++++++++++++++
 tb/tb_alu_result_checker.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_chk_pkg.sv
// Shared definitions for the ALU result checker: ALU control codes and checker FSM states.
package alu_chk_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/alu_result_checker_if.sv
// Valid/ready sample stream carrying ALU operands, DUT result and ALU control.
interface alu_result_checker_if #(
   parameter int WIDTH = 32
) ();
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_a;
   logic [WIDTH-1:0] s_b;
   logic [WIDTH-1:0] s_r;
   logic [2:0]       s_op;

   modport master (output s_valid, s_a, s_b, s_r, s_op, input s_ready);
   modport slave  (input s_valid, s_a, s_b, s_r, s_op, output s_ready);
endinterface

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: expected result for (a, b, op), flagging unsupported op codes.
module alu_ref_model
   import alu_chk_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [2:0]       i_op,
   output logic [WIDTH-1:0] o_exp,
   output logic             o_illegal
);

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
   always_comb begin
      o_exp     = '0;
      o_illegal = 1'b0;
      case (i_op)
         OP_AND:  o_exp = i_a & i_b;
         OP_OR:   o_exp = i_a | i_b;
         OP_ADD:  o_exp = i_a + i_b;
         OP_SUB:  o_exp = i_a - i_b;
         OP_SLT:  o_exp = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_result_checker.sv
// Stream-fed ALU result checker: one-stage compare pipeline, saturating pass/fail
// tallies and first-failure capture, sequenced by an IDLE/RUN/DRAIN/DONE FSM.
module alu_result_checker
   import alu_chk_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNT_W-1:0]     num_samples,
   alu_result_checker_if.slave  s,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CNT_W-1:0]     pass_count,
   output logic [CNT_W-1:0]     fail_count,
   output logic                 ff_valid,
   output logic [CNT_W-1:0]     ff_idx,
   output logic [WIDTH-1:0]     ff_a,
   output logic [WIDTH-1:0]     ff_b,
   output logic [WIDTH-1:0]     ff_r,
   output logic [WIDTH-1:0]     ff_exp
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           r_state, w_state_next;
   logic [CNT_W-1:0] r_remaining, r_idx;
   logic             r_cmp_valid;
   logic [CNT_W-1:0] r_cmp_idx;
   logic [WIDTH-1:0] r_cmp_a, r_cmp_b, r_cmp_r;
   logic [2:0]       r_cmp_op;
   logic [CNT_W-1:0] r_pass_count, r_fail_count, w_pass_next, w_fail_next;
   logic             r_pass, r_ff_valid;
   logic [CNT_W-1:0] r_ff_idx;
   logic [WIDTH-1:0] r_ff_a, r_ff_b, r_ff_r, r_ff_exp;
   logic [WIDTH-1:0] w_exp;
   logic             w_illegal, w_mismatch, w_hs, w_start_take;

   alu_ref_model #(.WIDTH(WIDTH)) u_ref (
      .i_a       (r_cmp_a),
      .i_b       (r_cmp_b),
      .i_op      (r_cmp_op),
      .o_exp     (w_exp),
      .o_illegal (w_illegal)
   );

   assign w_hs       = s.s_valid && (r_state == RUN);
   assign w_mismatch = w_illegal || (r_cmp_r != w_exp);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_start_take = 1'b0;
      case (r_state)
         IDLE, DONE: if (start) begin
            w_start_take = 1'b1;
            w_state_next = (num_samples == '0) ? DONE : RUN;
         end
         RUN:     if (w_hs && (r_remaining == CNT_W'(1))) w_state_next = DRAIN;
         DRAIN:   w_state_next = DONE;
         default: w_state_next = IDLE;
      endcase
   end

   // Tallies saturate rather than wrap; a new run clears them on the start edge.
   always_comb begin
      w_pass_next = r_pass_count;
      w_fail_next = r_fail_count;
      if (w_start_take) begin
         w_pass_next = '0;
         w_fail_next = '0;
      end else if (r_cmp_valid) begin
         if (w_mismatch) begin
            if (r_fail_count != CNT_MAX) w_fail_next = r_fail_count + CNT_W'(1);
         end else begin
            if (r_pass_count != CNT_MAX) w_pass_next = r_pass_count + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_remaining  <= '0;
         r_idx        <= '0;
         r_cmp_valid  <= 1'b0;
         r_cmp_idx    <= '0;
         r_cmp_a      <= '0;
         r_cmp_b      <= '0;
         r_cmp_r      <= '0;
         r_cmp_op     <= '0;
         r_pass_count <= '0;
         r_fail_count <= '0;
         r_pass       <= 1'b0;
         r_ff_valid   <= 1'b0;
         r_ff_idx     <= '0;
         r_ff_a       <= '0;
         r_ff_b       <= '0;
         r_ff_r       <= '0;
         r_ff_exp     <= '0;
      end else begin
         r_cmp_valid  <= w_hs;
         if (w_hs) begin
            r_cmp_idx   <= r_idx;
            r_cmp_a     <= s.s_a;
            r_cmp_b     <= s.s_b;
            r_cmp_r     <= s.s_r;
            r_cmp_op    <= s.s_op;
            r_idx       <= r_idx + CNT_W'(1);
            r_remaining <= r_remaining - CNT_W'(1);
         end
         if (w_start_take) begin
            r_idx       <= '0;
            r_remaining <= num_samples;
         end
         r_pass_count <= w_pass_next;
         r_fail_count <= w_fail_next;
         r_pass       <= (w_state_next == DONE) && (w_fail_next == '0);
         // Only the first failure of a run is kept; later ones never overwrite it.
         if (w_start_take) begin
            r_ff_valid <= 1'b0;
            r_ff_idx   <= '0;
            r_ff_a     <= '0;
            r_ff_b     <= '0;
            r_ff_r     <= '0;
            r_ff_exp   <= '0;
         end else if (r_cmp_valid && w_mismatch && !r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_idx   <= r_cmp_idx;
            r_ff_a     <= r_cmp_a;
            r_ff_b     <= r_cmp_b;
            r_ff_r     <= r_cmp_r;
            r_ff_exp   <= w_illegal ? '0 : w_exp;
         end
      end
   end

   assign s.s_ready  = (r_state == RUN);
   assign busy       = (r_state == RUN) || (r_state == DRAIN);
   assign done       = (r_state == DONE);
   assign pass       = r_pass;
   assign pass_count = r_pass_count;
   assign fail_count = r_fail_count;
   assign ff_valid   = r_ff_valid;
   assign ff_idx     = r_ff_idx;
   assign ff_a       = r_ff_a;
   assign ff_b       = r_ff_b;
   assign ff_r       = r_ff_r;
   assign ff_exp     = r_ff_exp;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: hand-computed vectors checked with immediate assertions.
module tb_alu_result_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] num_samples = '0;
   logic        busy, done, pass, ff_valid;
   logic [15:0] pass_count, fail_count, ff_idx;
   logic [31:0] ff_a, ff_b, ff_r, ff_exp;
   int          n_cmp = 0;
   int          n_err = 0;

   alu_result_checker_if #(.WIDTH(32)) bus ();

   alu_result_checker #(.WIDTH(32), .CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_samples (num_samples),
      .s           (bus),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .pass_count  (pass_count),
      .fail_count  (fail_count),
      .ff_valid    (ff_valid),
      .ff_idx      (ff_idx),
      .ff_a        (ff_a),
      .ff_b        (ff_b),
      .ff_r        (ff_r),
      .ff_exp      (ff_exp)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input logic [15:0] n);
      num_samples = n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Presents one sample and returns just after the edge on which it was accepted.
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r);
      int n = 0;
      bus.s_op = op; bus.s_a = a; bus.s_b = b; bus.s_r = r;
      bus.s_valid = 1'b1;
      while (!bus.s_ready && n < 20) begin
         tick();
         n++;
      end
      if (!bus.s_ready) begin
         n_cmp++;
         n_err++;
         $error("FAIL hs_timeout: observed s_ready=0 expected 1 within 20 cycles");
      end else begin
         tick();
      end
      bus.s_valid = 1'b0;
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_a = '0; bus.s_b = '0; bus.s_r = '0; bus.s_op = '0;
      tick(); tick();
      check("rst_ready", bus.s_ready, 0);
      check("rst_busy",  busy, 0);
      check("rst_done",  done, 0);
      check("rst_pass",  pass, 0);
      check("rst_pcnt",  pass_count, 0);
      check("rst_fcnt",  fail_count, 0);
      check("rst_ffv",   ff_valid, 0);
      rst = 1'b0;
      tick();

      // Empty run goes straight to DONE with pass.
      bus.s_valid = 1'b1;
      pulse_start(16'd0);
      bus.s_valid = 1'b0;
      check("zero_done",  done, 1);
      check("zero_pass",  pass, 1);
      check("zero_ready", bus.s_ready, 0);
      check("zero_pcnt",  pass_count, 0);
      check("zero_fcnt",  fail_count, 0);

      // Four correct AND samples.
      pulse_start(16'd4);
      check("and_busy",  busy, 1);
      check("and_ready", bus.s_ready, 1);
      send(3'b000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000);
      send(3'b000, 32'h0000_0001, 32'h8000_0001, 32'h0000_0001);
      send(3'b000, 32'h8000_0000, 32'h8000_0001, 32'h8000_0000);
      send(3'b000, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001);
      check("and_drain_done",  done, 0);
      check("and_drain_busy",  busy, 1);
      check("and_drain_ready", bus.s_ready, 0);
      check("and_drain_pcnt",  pass_count, 3);
      tick();
      check("and_done", done, 1);
      check("and_pass", pass, 1);
      check("and_pcnt", pass_count, 4);
      check("and_fcnt", fail_count, 0);
      check("and_ffv",  ff_valid, 0);

      // Restart from DONE; first failure at index 1 must survive a second failure.
      pulse_start(16'd3);
      check("ff_restart_done", done, 0);
      check("ff_restart_pcnt", pass_count, 0);
      send(3'b010, 32'd2, 32'd3, 32'd5);
      check("ff_latency_pcnt", pass_count, 0);
      send(3'b000, 32'h8000_0001, 32'h0000_0001, 32'h0000_0000);
      check("ff_s0_pcnt", pass_count, 1);
      send(3'b001, 32'h0000_00F0, 32'h0000_000F, 32'h1234_5678);
      tick();
      check("ff_done",  done, 1);
      check("ff_pass",  pass, 0);
      check("ff_pcnt",  pass_count, 1);
      check("ff_fcnt",  fail_count, 2);
      check("ff_valid", ff_valid, 1);
      check("ff_idx",   ff_idx, 1);
      check("ff_a",     ff_a, 32'h8000_0001);
      check("ff_b",     ff_b, 32'h0000_0001);
      check("ff_r",     ff_r, 32'h0000_0000);
      check("ff_exp",   ff_exp, 32'h0000_0001);

      // Signed SLT and wrapping ADD.
      pulse_start(16'd2);
      send(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
      send(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
      tick();
      check("sign_pcnt", pass_count, 2);
      check("sign_fcnt", fail_count, 0);
      check("sign_pass", pass, 1);

      // Illegal op, plus a start pulse in RUN that must be ignored.
      pulse_start(16'd2);
      send(3'b011, 32'd5, 32'd3, 32'd1);
      pulse_start(16'd7);
      check("ill_busy", busy, 1);
      check("ill_fcnt_mid", fail_count, 1);
      send(3'b000, 32'd3, 32'd5, 32'd1);
      tick();
      check("ill_done",   done, 1);
      check("ill_pass",   pass, 0);
      check("ill_fcnt",   fail_count, 1);
      check("ill_pcnt",   pass_count, 1);
      check("ill_ffidx",  ff_idx, 0);
      check("ill_ffr",    ff_r, 32'd1);
      check("ill_ffexp",  ff_exp, 32'd0);

      // Bubbles, then an asynchronous reset part way through a 5-sample run.
      pulse_start(16'd5);
      tick(); tick();
      check("gap_busy", busy, 1);
      check("gap_pcnt", pass_count, 0);
      send(3'b110, 32'd10, 32'd3, 32'd7);
      tick(); tick();
      send(3'b000, 32'hFFFF_0000, 32'h00FF_FF00, 32'h00FF_0000);
      check("gap_pcnt2", pass_count, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_busy",  busy, 0);
      check("arst_ready", bus.s_ready, 0);
      check("arst_done",  done, 0);
      check("arst_pass",  pass, 0);
      check("arst_pcnt",  pass_count, 0);
      check("arst_fcnt",  fail_count, 0);
      check("arst_ffv",   ff_valid, 0);
      #1 rst = 1'b0;
      tick();

      // Clean run after the reset.
      pulse_start(16'd1);
      send(3'b010, 32'd1, 32'd1, 32'd2);
      tick();
      check("fresh_done", done, 1);
      check("fresh_pass", pass, 1);
      check("fresh_pcnt", pass_count, 1);
      check("fresh_fcnt", fail_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
